// File: rtl/store_retire_buffer.sv
// Store retire buffer: captures up to NUM_SUPER retiring stores per cycle into a circular
// FIFO, drains them to the D-cache one per cycle, and forwards resident data to loads.
module store_retire_buffer #(
    parameter int NUM_SUPER = 2,
    parameter int NUM_WB    = 8,
    parameter int ADDR_W    = 61,
    parameter int DATA_W    = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_SUPER-1:0]          sq_wr_en,
    input  logic [NUM_SUPER*ADDR_W-1:0]   sq_addr,
    input  logic [NUM_SUPER*DATA_W-1:0]   sq_value,
    output logic                          wb_ready,
    output logic                          dc_wr_req,
    output logic [ADDR_W-1:0]             dc_wr_addr,
    output logic [DATA_W-1:0]             dc_wr_value,
    input  logic                          dc_wr_ack,
    input  logic [NUM_SUPER*ADDR_W-1:0]   ld_addr,
    output logic [NUM_SUPER-1:0]          ld_hit,
    output logic [NUM_SUPER*DATA_W-1:0]   ld_value,
    output logic                          wb_empty,
    output logic                          wb_overflow
);

    localparam int PTR_W = $clog2(NUM_WB);
    localparam int CNT_W = $clog2(NUM_WB + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SUPER-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_SUPER; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic [ADDR_W-1:0] addr_mem_r [NUM_WB];
    logic [DATA_W-1:0] data_mem_r [NUM_WB];

    logic [CNT_W-1:0]  enq_cnt_s;
    logic [CNT_W-1:0]  free_s;
    logic              enq_fits_s;
    logic              pop_s;
    logic [PTR_W-1:0]  lane_off_s [NUM_SUPER];
    logic [NUM_SUPER-1:0]        ld_hit_s;
    logic [NUM_SUPER*DATA_W-1:0] ld_value_s;

    assign free_s      = CNT_W'(NUM_WB) - count_r;
    assign wb_ready    = (free_s >= CNT_W'(NUM_SUPER));
    assign wb_empty    = (count_r == {CNT_W{1'b0}});
    assign wb_overflow = overflow_r;
    assign dc_wr_req   = en && (count_r != {CNT_W{1'b0}});
    assign dc_wr_addr  = addr_mem_r[head_r];
    assign dc_wr_value = data_mem_r[head_r];
    assign ld_hit      = ld_hit_s;
    assign ld_value    = ld_value_s;

    // Enqueue planning: compact valid lanes in lane order and decide whether the batch fits.
    always_comb begin
        logic [PTR_W-1:0] run_v;
        enq_cnt_s  = popcount(sq_wr_en);
        enq_fits_s = (enq_cnt_s <= free_s);
        pop_s      = dc_wr_req && dc_wr_ack;
        run_v      = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_SUPER; i++) begin
            lane_off_s[i] = run_v;
            if (sq_wr_en[i]) begin
                run_v = run_v + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                run_v = run_v;
            end
        end
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (en) begin
            if (pop_s) begin
                head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (enq_fits_s) begin
                tail_r  <= tail_r + PTR_W'(enq_cnt_s);
                count_r <= count_r + enq_cnt_s - {{(CNT_W-1){1'b0}}, pop_s};
            end else begin
                // A batch that does not fit is dropped whole; the pop still happens.
                count_r    <= count_r - {{(CNT_W-1){1'b0}}, pop_s};
                overflow_r <= 1'b1;
            end
        end
    end

    // Entry storage: each valid lane lands at tail plus its compacted offset.
    always_ff @(posedge clock) begin
        if (!reset && en && enq_fits_s) begin
            for (int i = 0; i < NUM_SUPER; i++) begin
                if (sq_wr_en[i]) begin
                    addr_mem_r[tail_r + lane_off_s[i]] <= sq_addr[i*ADDR_W +: ADDR_W];
                    data_mem_r[tail_r + lane_off_s[i]] <= sq_value[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Load forwarding: walk oldest to youngest so the youngest match is the last one kept.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        ld_hit_s   = {NUM_SUPER{1'b0}};
        ld_value_s = {(NUM_SUPER*DATA_W){1'b0}};
        idx_v      = {PTR_W{1'b0}};
        for (int l = 0; l < NUM_SUPER; l++) begin
            for (int k = 0; k < NUM_WB; k++) begin
                idx_v = head_r + PTR_W'(k);
                if ((CNT_W'(k) < count_r) && (addr_mem_r[idx_v] == ld_addr[l*ADDR_W +: ADDR_W])) begin
                    ld_hit_s[l]                    = 1'b1;
                    ld_value_s[l*DATA_W +: DATA_W] = data_mem_r[idx_v];
                end else begin
                    ld_hit_s[l] = ld_hit_s[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_store_retire_buffer.sv
// Scoreboard bench for store_retire_buffer: a queue-based model predicts flags, forwarding
// and the D-cache write sequence; a separate monitor checks every accepted write.
module tb_store_retire_buffer;

    localparam int NS = 2;
    localparam int NW = 8;
    localparam int AW = 61;
    localparam int DW = 64;

    logic            clock = 1'b0;
    logic            reset;
    logic            en;
    logic [NS-1:0]   sq_wr_en;
    logic [NS*AW-1:0] sq_addr;
    logic [NS*DW-1:0] sq_value;
    logic            wb_ready;
    logic            dc_wr_req;
    logic [AW-1:0]   dc_wr_addr;
    logic [DW-1:0]   dc_wr_value;
    logic            dc_wr_ack;
    logic [NS*AW-1:0] ld_addr;
    logic [NS-1:0]   ld_hit;
    logic [NS*DW-1:0] ld_value;
    logic            wb_empty;
    logic            wb_overflow;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t exp_q[$];
    logic m_ovf;
    int   total = 0;
    int   bad   = 0;

    store_retire_buffer #(.NUM_SUPER(NS), .NUM_WB(NW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .en(en),
        .sq_wr_en(sq_wr_en), .sq_addr(sq_addr), .sq_value(sq_value),
        .wb_ready(wb_ready), .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr),
        .dc_wr_value(dc_wr_value), .dc_wr_ack(dc_wr_ack), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_value(ld_value), .wb_empty(wb_empty), .wb_overflow(wb_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted write must match the oldest expected write.
    always @(negedge clock) begin
        ent_t e;
        if (reset === 1'b0 && dc_wr_req === 1'b1 && dc_wr_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h none expected", dc_wr_addr);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", dc_wr_addr, e.a);
                chk("wr_value", dc_wr_value, e.d);
            end
        end
    end

    task automatic st(input logic [AW-1:0] a0, input logic [DW-1:0] v0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] v1);
        sq_addr  = {a1, a0};
        sq_value = {v1, v0};
    endtask

    task automatic probe(input logic [AW-1:0] l0, input logic [AW-1:0] l1);
        ld_addr = {l1, l0};
    endtask

    // One clock cycle: drive, predict, check at negedge, advance the model.
    task automatic cyc(input logic r, input logic e, input logic [1:0] we, input logic ack);
        logic          pop;
        logic [1:0]    eh;
        logic [DW-1:0] ev [2];
        int            n;
        int            free;
        ent_t          t;
        reset     = r;
        en        = e;
        sq_wr_en  = we;
        dc_wr_ack = ack;
        pop = !r && e && ack && (mq.size() > 0);
        if (pop) exp_q.push_back(mq[0]);
        for (int l = 0; l < 2; l++) begin
            eh[l] = 1'b0;
            ev[l] = '0;
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].a == ld_addr[l*AW +: AW]) begin
                    eh[l] = 1'b1;
                    ev[l] = mq[k].d;
                end
            end
        end
        @(negedge clock);
        chk("dc_wr_req", dc_wr_req, e && (mq.size() > 0));
        chk("wb_ready", wb_ready, (NW - mq.size()) >= NS);
        chk("wb_empty", wb_empty, mq.size() == 0);
        chk("wb_overflow", wb_overflow, m_ovf);
        chk("ld_hit", ld_hit, eh);
        for (int l = 0; l < 2; l++) begin
            if (eh[l]) chk("ld_value", ld_value[l*DW +: DW], ev[l]);
        end
        if (e && mq.size() > 0) begin
            chk("dc_wr_addr", dc_wr_addr, mq[0].a);
            chk("dc_wr_value", dc_wr_value, mq[0].d);
        end
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (e) begin
            n    = int'(we[0]) + int'(we[1]);
            free = NW - mq.size();
            if (pop) void'(mq.pop_front());
            if (n > free) begin
                m_ovf = 1'b1;
            end else begin
                for (int l = 0; l < 2; l++) begin
                    if (we[l]) begin
                        t.a = sq_addr[l*AW +: AW];
                        t.d = sq_value[l*DW +: DW];
                        mq.push_back(t);
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            cyc(1'b0, 1'b1, 2'b00, 1'b1);
            guard++;
        end
        if (mq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d entries left want 0", mq.size());
        end
    endtask

    initial begin
        int            pushed;
        int            guard;
        logic          tog;
        logic [1:0]    we;
        logic [AW-1:0] ra0, ra1;
        reset = 1'b1; en = 1'b0; sq_wr_en = '0; sq_addr = '0; sq_value = '0;
        dc_wr_ack = 1'b0; ld_addr = '0; m_ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Single lane-0 store, held then acknowledged.
        st(61'h10, 64'hAA, 61'h0, 64'h0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);

        // Lone lane-1 store, then both lanes; drain in order.
        st(61'h0, 64'h0, 61'h20, 64'hBB);
        cyc(1'b0, 1'b1, 2'b10, 1'b0);
        st(61'h21, 64'h1, 61'h22, 64'h2);
        cyc(1'b0, 1'b1, 2'b11, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 2'b00, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);

        // Fill to 6, then 7, then an overflowing two-lane batch with a pop.
        st(61'h40, 64'h1, 61'h41, 64'h2);
        repeat (3) cyc(1'b0, 1'b1, 2'b11, 1'b0);
        st(61'h42, 64'h3, 61'h43, 64'h4);
        cyc(1'b0, 1'b1, 2'b01, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        drain();
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        cyc(1'b1, 1'b1, 2'b00, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);

        // Forwarding: youngest of two same-address stores wins.
        probe(61'h30, 61'h31);
        st(61'h30, 64'h1, 61'h0, 64'h0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0);
        st(61'h30, 64'h2, 61'h0, 64'h0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);

        // Wrap-around: 20 stores, two lanes when there is room, ack toggling.
        pushed = 0; guard = 0; tog = 1'b1;
        while (pushed < 20 && guard < 200) begin
            st(61'h100 + 61'(pushed), 64'(pushed) + 64'h1000,
               61'h101 + 61'(pushed), 64'(pushed) + 64'h1001);
            if (mq.size() <= NW - 2) begin
                we = 2'b11;
                pushed += 2;
            end else begin
                we = 2'b00;
            end
            cyc(1'b0, 1'b1, we, tog);
            tog = ~tog;
            guard++;
        end
        if (pushed < 20) begin
            total++;
            bad++;
            $display("FAIL wrap_timeout: got %0d pushed want 20", pushed);
        end
        drain();

        // Reset with 5 entries and ack high; then en low freezes state.
        st(61'h50, 64'h5, 61'h51, 64'h6);
        cyc(1'b0, 1'b1, 2'b11, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 1'b0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0);
        cyc(1'b1, 1'b1, 2'b00, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        st(61'h52, 64'h7, 61'h53, 64'h8);
        cyc(1'b0, 1'b1, 2'b11, 1'b0);
        cyc(1'b0, 1'b0, 2'b11, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        drain();

        // Randomized traffic over a small address range to exercise forwarding hits.
        for (int i = 0; i < 400; i++) begin
            ra0 = 61'h60 + 61'($urandom_range(0, 7));
            ra1 = 61'h60 + 61'($urandom_range(0, 7));
            st(ra0, {$urandom, $urandom}, ra1, {$urandom, $urandom});
            probe(61'h60 + 61'($urandom_range(0, 7)), 61'h60 + 61'($urandom_range(0, 7)));
            we = 2'($urandom);
            if (mq.size() > NW - 2 && $urandom_range(0, 9) != 0) we = 2'b00;
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), we, 1'($urandom));
        end
        drain();
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_retire_buffer.md
Name: store_retire_buffer

Overview:
- Sits directly downstream of the store queue: captures up to NUM_SUPER retiring stores per cycle (SQ wr_en/addr/value bundle).
- Holds them in a circular FIFO and drains them to the D-cache one per cycle over a req/ack handshake.
- Forwards committed-but-not-yet-written data to in-flight loads so the load queue never reads stale cache data.
- Lets SQ retirement proceed without waiting on D-cache write latency.

Parameters:
NUM_SUPER, 2, retire lanes per cycle
NUM_WB, 8, buffer entries (power of two, >= 2*NUM_SUPER)
ADDR_W, 61, quadword address width (byte address [63:3])
DATA_W, 64, store data width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  global stall-release; 0 freezes all state
sq_wr_en  in  NUM_SUPER  per-lane retiring-store valid; lane 0 is older
sq_addr  in  NUM_SUPER*ADDR_W  per-lane store quadword address
sq_value  in  NUM_SUPER*DATA_W  per-lane store data
wb_ready  out  1  free entries >= NUM_SUPER; SQ may retire stores only when 1
dc_wr_req  out  1  head entry valid, write requested
dc_wr_addr  out  ADDR_W  head entry address
dc_wr_value  out  DATA_W  head entry data
dc_wr_ack  in  1  D-cache accepted the write this cycle
ld_addr  in  NUM_SUPER*ADDR_W  per-lane load quadword address probe
ld_hit  out  NUM_SUPER  resident entry matches ld_addr[i]
ld_value  out  NUM_SUPER*DATA_W  data of youngest matching entry
wb_empty  out  1  count == 0
wb_overflow  out  1  sticky error: enqueue attempted without room

Behaviour:
- State: head, tail (clog2(NUM_WB) bits, wrap modulo NUM_WB); count (clog2(NUM_WB+1) bits); entry array {addr, value}.
- Reset: head = tail = count = 0; wb_overflow = 0; dc_wr_req = 0; wb_ready = 1; wb_empty = 1; ld_hit = 0; entry contents don't-care.
- Reset mid-operation discards every entry, including one being presented with ack in the same cycle. No write completes that cycle.
- en = 0: no enqueue, no pop, no flag update. dc_wr_req is forced 0. Forwarding outputs stay live.

Enqueue, when en = 1:
- Lanes with sq_wr_en set are compacted in lane order. Lane 0 goes to tail, next valid lane to tail+1.
- A lone lane-1 store goes to tail.
- tail advances by popcount(sq_wr_en).

Drain:
- dc_wr_req = (count != 0) && en. dc_wr_addr/dc_wr_value are taken from the head entry.
- A pop occurs on dc_wr_req && dc_wr_ack; head advances by 1 next cycle.
- dc_wr_ack while dc_wr_req = 0 is ignored.
- Request fields must stay stable while req = 1 and ack = 0.

Count and flags:
- next count = count + enq − pop. Simultaneous enqueue and pop are both honoured.
- wb_ready = (NUM_WB − count) >= NUM_SUPER, computed from registered count only. A same-cycle pop does not raise it.
- wb_empty = (count == 0).

Overflow:
- If enqueues exceed free entries (NUM_WB − count), the entire cycle's enqueue is dropped and wb_overflow sets and stays set until reset.
- Pop in that cycle proceeds normally.

Forwarding (combinational, resident entries only):
- Scan from tail−1 back to head. The first entry whose addr == ld_addr[i] gives ld_hit[i] = 1 and ld_value[i] = its value (youngest wins).
- Stores enqueued in the same cycle are not visible. The SQ still covers them that cycle.
- The head entry being popped this cycle is still visible.
- ld_value is don't-care when ld_hit = 0.

No coalescing: repeated stores to one address occupy separate entries and drain in order.

Latency:
- Enqueue to earliest dc_wr_req is 1 cycle (entry visible the cycle after capture).
- Sustained drain is 1 entry per cycle with ack held high.

Test Plan:
- Reset, then lane0 store addr 0x10/value 0xAA with ack = 0 -> next cycle dc_wr_req = 1, addr 0x10, value 0xAA, count 1, wb_empty = 0; ack = 1 -> following cycle dc_wr_req = 0, wb_empty = 1.
- Only lane1 valid (addr 0x20, value 0xBB), then lanes 0+1 (0x21/0x1, 0x22/0x2) -> drain order 0x20, 0x21, 0x22 with ack held 1, one per cycle.
- Fill to count 6 with NUM_WB = 8 -> wb_ready = 1; count 7 -> wb_ready = 0; two-lane enqueue at count 7 -> dropped, count stays 7 (or 6 if ack), wb_overflow = 1 until reset.
- Enqueue 0x30/0x1 then 0x30/0x2, probe ld_addr[0] = 0x30, ld_addr[1] = 0x31 -> ld_hit = 2'b01, ld_value[0] = 0x2; after both drain -> ld_hit = 0.
- Wrap-around: push and pop 20 stores with steady two-lane enqueue and ack toggling 1/0 -> written sequence matches input order exactly, no loss, no overflow.
- Assert reset while count = 5 and ack = 1 -> next cycle count 0, dc_wr_req = 0, no extra write observed; en = 0 for 3 cycles with count 2 -> dc_wr_req = 0 and count frozen at 2.
